mirfak_alu_decode: RTL and testbench
====================================

Name: mirfak_alu_decode

Overview:
- Decode/issue stage that produces the ALU control word and operands from RV32I integer instructions (OP, OP-IMM, LUI, AUIPC).
- Registered output feeds mirfak_alu directly in the execute stage.
- Valid/ready handshake on both sides; 2-entry skid buffer keeps ready_o registered at full throughput.
- Flags illegal encodings for the exception unit.

Parameters:
- RESET_PC_ZERO, 1, when 1 all data outputs reset to 0; when 0 data outputs have no reset (control flags still reset).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous pipeline flush
- valid_i  in  1  upstream instruction valid
- ready_o  out  1  stage can accept (registered)
- instruction_i  in  32  raw instruction
- pc_i  in  32  instruction address
- rs1_data_i  in  32  register-file read port 1
- rs2_data_i  in  32  register-file read port 2
- valid_o  out  1  output entry valid
- ready_i  in  1  execute stage accepts
- operand_a_o  out  32  ALU operand A
- operand_b_o  out  32  ALU operand B
- adder_op_o  out  1  0 = ADD, 1 = SUB
- logic_op_o  out  2  00 = AND, 01 = OR, 10 = XOR
- shift_op_o  out  2  00 = LL, 01 = LR, 10 = AR
- compare_op_o  out  1  0 = signed LT, 1 = unsigned LTU
- alu_op_o  out  2  00 = ADDER, 01 = LOGIC, 10 = SHIFT, 11 = COMPARE
- rd_o  out  5  destination register
- rd_we_o  out  1  write-back enable
- illegal_o  out  1  illegal instruction

Behaviour:
- Reset (async, rst_i high):
  - valid_o = 0, skid entry empty, ready_o = 1.
  - All other outputs 0 (RESET_PC_ZERO = 1).
  - Reset mid-transfer discards both entries immediately.
- Handshake:
  - Input accepted when valid_i & ready_o.
  - Output consumed when valid_o & ready_i.
  - valid_o/data are stable while valid_o & !ready_i.
- Latency and throughput:
  - Latency 1 cycle from accept to valid_o when the output register is empty or being consumed.
  - Throughput 1 instruction/cycle.
- Skid buffer:
  - Accept while output is held (valid_o & !ready_i): the entry goes to the skid register; ready_o drops next cycle.
  - On the next consume, the skid entry moves to output; ready_o rises the cycle after.
  - Ordering is strictly FIFO.
- Flush (flush_i = 1):
  - Next cycle: valid_o = 0, skid empty, ready_o = 1.
  - An input offered in the flush cycle is dropped.
  - Flush has priority over accept and consume.
- Decode for OP (0110011):
  - a = rs1_data_i, b = rs2_data_i.
  - funct3 000: ADD (funct7 0x00) or SUB (funct7 0x20).
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR. 101: SRL (0x00) or SRA (0x20). 110: OR. 111: AND.
  - Any other funct7 is illegal.
- Decode for OP-IMM (0010011):
  - a = rs1_data_i, b = sign-extended inst[31:20].
  - Same funct3 map as OP, with no SUB.
  - SLLI requires inst[31:25] = 0; SRLI/SRAI require inst[31:25] = 0x00/0x20; otherwise illegal.
- Decode for LUI (0110111): a = 0, b = {inst[31:12], 12'b0}, ADDER/ADD.
- Decode for AUIPC (0010111): a = pc_i, b = {inst[31:12], 12'b0}, ADDER/ADD.
- Any other opcode is illegal.
- Illegal instructions:
  - illegal_o = 1, rd_we_o = 0, operands and op fields 0.
  - The entry still passes through the handshake normally.
- rd_we_o = legal & (rd != 0).
- Unused op fields for a given alu_op are driven 0, never X.

Decomposition:
- Shared header mirfak_defines.vh holds:
  - ALU_OP_*, ADDER_OP_*, LOGIC_OP_*, SHIFT_OP_*, COMPARE_* encodings above.
  - RV32I opcode/funct3/funct7 constants.
- The ALU includes the same header, so the encodings are single-sourced.
- One sub-module, mirfak_skid_buffer:
  - Generic WIDTH-parameterised 2-entry valid/ready skid.
  - Holds the packed {illegal, rd_we, rd, ops, b, a} word.
- Decode logic stays combinational in the top ahead of the skid.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7, ready_i = 1 -> next cycle valid_o = 1, alu_op = 00, adder_op = 0, a = 5, b = 7, rd = 3, rd_we = 1.
- SRAI x5,x6,4 (0x40435293), rs1 = 0x80000000 -> alu_op = 10, shift_op = 10, b = 0x00000404, rd = 5; LUI x1,0x12345 (0x123450B7) -> a = 0, b = 0x12345000, ADDER/ADD.
- AUIPC x2,0x1 (0x00001117), pc = 0x100 -> a = 0x100, b = 0x1000; SLTU x4,x1,x2 (0x0020B233) -> alu_op = 11, compare_op = 1.
- ready_i = 0, three back-to-back valid_i -> first two accepted, ready_o = 0 on the cycle after the second accept; raise ready_i -> both emitted in order on consecutive cycles, third accepted once ready_o = 1.
- 0x022081B3 (funct7 0x01) and 0x00000073 -> illegal_o = 1, rd_we_o = 0, handshake completes.
- Two entries held, pulse flush_i with valid_i = 1 -> next cycle valid_o = 0, ready_o = 1, nothing emitted; repeat with rst_i asserted mid-cycle -> outputs clear asynchronously.

Source files
------------

// File: rtl/mirfak_alu_decode_pkg.sv
// Shared ALU control encodings, RV32I opcode/funct constants and the packed decode word.
// Included by the decode stage and the ALU so the encodings exist in one place only.
package mirfak_alu_decode_pkg;

    localparam logic [1:0] ALU_OP_ADDER   = 2'b00;
    localparam logic [1:0] ALU_OP_LOGIC   = 2'b01;
    localparam logic [1:0] ALU_OP_SHIFT   = 2'b10;
    localparam logic [1:0] ALU_OP_COMPARE = 2'b11;

    localparam logic ADDER_OP_ADD = 1'b0;
    localparam logic ADDER_OP_SUB = 1'b1;

    localparam logic [1:0] LOGIC_OP_AND = 2'b00;
    localparam logic [1:0] LOGIC_OP_OR  = 2'b01;
    localparam logic [1:0] LOGIC_OP_XOR = 2'b10;

    localparam logic [1:0] SHIFT_OP_LL = 2'b00;
    localparam logic [1:0] SHIFT_OP_LR = 2'b01;
    localparam logic [1:0] SHIFT_OP_AR = 2'b10;

    localparam logic COMPARE_LT  = 1'b0;
    localparam logic COMPARE_LTU = 1'b1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic        illegal;
        logic        rd_we;
        logic [4:0]  rd;
        logic [1:0]  alu_op;
        logic        compare_op;
        logic [1:0]  shift_op;
        logic [1:0]  logic_op;
        logic        adder_op;
        logic [31:0] b;
        logic [31:0] a;
    } alu_ctrl_t;

    function automatic logic [31:0] sext_i_imm(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

endpackage

// File: rtl/mirfak_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid slot,
// with ready_o driven straight from a flop.
module mirfak_skid_buffer #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          RESET_DATA = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             accept, consume;

    assign accept  = valid_i & ready_q;
    assign consume = out_valid_q & ready_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_data_d   = out_data_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || consume) begin
            // ready_q is low while the skid slot is full, so no accept can race the refill.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = data_i;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = data_i;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    if (RESET_DATA) begin : g_data_rst
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                out_data_q  <= '0;
                skid_data_q <= '0;
            end else begin
                out_data_q  <= out_data_d;
                skid_data_q <= skid_data_d;
            end
        end
    end else begin : g_data_nrst
        always_ff @(posedge clk_i) begin
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;

endmodule

// File: rtl/mirfak_alu_decode.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode stage: builds the ALU control word combinationally
// and registers it through a skid buffer toward the execute stage.
module mirfak_alu_decode
    import mirfak_alu_decode_pkg::*;
#(
    parameter bit RESET_PC_ZERO = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] instruction_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] operand_a_o,
    output logic [31:0] operand_b_o,
    output logic        adder_op_o,
    output logic [1:0]  logic_op_o,
    output logic [1:0]  shift_op_o,
    output logic        compare_op_o,
    output logic [1:0]  alu_op_o,
    output logic [4:0]  rd_o,
    output logic        rd_we_o,
    output logic        illegal_o
);

    localparam int unsigned CtrlWidth = $bits(alu_ctrl_t);

    alu_ctrl_t  dec_ctrl;
    alu_ctrl_t  out_ctrl;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       is_imm, f7_base, f7_alt, legal;

    assign opcode  = instruction_i[6:0];
    assign rd      = instruction_i[11:7];
    assign funct3  = instruction_i[14:12];
    assign funct7  = instruction_i[31:25];
    assign is_imm  = (opcode == OPC_OP_IMM);
    assign f7_base = (funct7 == F7_BASE);
    assign f7_alt  = (funct7 == F7_ALT);

    always_comb begin
        dec_ctrl = '0;
        legal    = 1'b0;
        unique case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec_ctrl.a = rs1_data_i;
                dec_ctrl.b = is_imm ? sext_i_imm(instruction_i) : rs2_data_i;
                // For OP-IMM, funct7 is part of the immediate except on shifts.
                case (funct3)
                    F3_ADD_SUB: begin
                        dec_ctrl.alu_op   = ALU_OP_ADDER;
                        dec_ctrl.adder_op = (!is_imm && f7_alt) ? ADDER_OP_SUB : ADDER_OP_ADD;
                        legal             = is_imm || f7_base || f7_alt;
                    end
                    F3_SLL: begin
                        dec_ctrl.alu_op   = ALU_OP_SHIFT;
                        dec_ctrl.shift_op = SHIFT_OP_LL;
                        legal             = f7_base;
                    end
                    F3_SLT: begin
                        dec_ctrl.alu_op     = ALU_OP_COMPARE;
                        dec_ctrl.compare_op = COMPARE_LT;
                        legal               = is_imm || f7_base;
                    end
                    F3_SLTU: begin
                        dec_ctrl.alu_op     = ALU_OP_COMPARE;
                        dec_ctrl.compare_op = COMPARE_LTU;
                        legal               = is_imm || f7_base;
                    end
                    F3_XOR: begin
                        dec_ctrl.alu_op   = ALU_OP_LOGIC;
                        dec_ctrl.logic_op = LOGIC_OP_XOR;
                        legal             = is_imm || f7_base;
                    end
                    F3_SRL_SRA: begin
                        dec_ctrl.alu_op   = ALU_OP_SHIFT;
                        dec_ctrl.shift_op = f7_alt ? SHIFT_OP_AR : SHIFT_OP_LR;
                        legal             = f7_base || f7_alt;
                    end
                    F3_OR: begin
                        dec_ctrl.alu_op   = ALU_OP_LOGIC;
                        dec_ctrl.logic_op = LOGIC_OP_OR;
                        legal             = is_imm || f7_base;
                    end
                    default: begin
                        dec_ctrl.alu_op   = ALU_OP_LOGIC;
                        dec_ctrl.logic_op = LOGIC_OP_AND;
                        legal             = is_imm || f7_base;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_ctrl.b = {instruction_i[31:12], 12'b0};
                legal      = 1'b1;
            end
            OPC_AUIPC: begin
                dec_ctrl.a = pc_i;
                dec_ctrl.b = {instruction_i[31:12], 12'b0};
                legal      = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Illegal entries carry only the flag and rd; operands and op fields are zeroed.
        if (!legal) begin
            dec_ctrl         = '0;
            dec_ctrl.illegal = 1'b1;
        end
        dec_ctrl.rd    = rd;
        dec_ctrl.rd_we = legal && (rd != 5'd0);
    end

    mirfak_skid_buffer #(
        .WIDTH      (CtrlWidth),
        .RESET_DATA (RESET_PC_ZERO)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (dec_ctrl),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (out_ctrl)
    );

    assign operand_a_o  = out_ctrl.a;
    assign operand_b_o  = out_ctrl.b;
    assign adder_op_o   = out_ctrl.adder_op;
    assign logic_op_o   = out_ctrl.logic_op;
    assign shift_op_o   = out_ctrl.shift_op;
    assign compare_op_o = out_ctrl.compare_op;
    assign alu_op_o     = out_ctrl.alu_op;
    assign rd_o         = out_ctrl.rd;
    assign rd_we_o      = out_ctrl.rd_we;
    assign illegal_o    = out_ctrl.illegal;

endmodule

// File: tb/tb_mirfak_alu_decode.sv
// Scoreboard bench for mirfak_alu_decode: directed instructions with hand-computed control words.
module tb_mirfak_alu_decode;
    import mirfak_alu_decode_pkg::*;

    logic        clk_i, rst_i, flush_i, valid_i, ready_o, valid_o, ready_i;
    logic [31:0] instruction_i, pc_i, rs1_data_i, rs2_data_i;
    logic [31:0] operand_a_o, operand_b_o;
    logic        adder_op_o, compare_op_o, rd_we_o, illegal_o;
    logic [1:0]  logic_op_o, shift_op_o, alu_op_o;
    logic [4:0]  rd_o;

    mirfak_alu_decode #(
        .RESET_PC_ZERO (1'b1)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .instruction_i (instruction_i),
        .pc_i          (pc_i),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .operand_a_o   (operand_a_o),
        .operand_b_o   (operand_b_o),
        .adder_op_o    (adder_op_o),
        .logic_op_o    (logic_op_o),
        .shift_op_o    (shift_op_o),
        .compare_op_o  (compare_op_o),
        .alu_op_o      (alu_op_o),
        .rd_o          (rd_o),
        .rd_we_o       (rd_we_o),
        .illegal_o     (illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    alu_ctrl_t exp_q[$];
    alu_ctrl_t dut_word, held_word, popped;
    int        checks = 0;
    int        errors = 0;
    int        emitted = 0;
    bit        held = 1'b0;

    assign dut_word = {illegal_o, rd_we_o, rd_o, alu_op_o, compare_op_o, shift_op_o,
                       logic_op_o, adder_op_o, operand_b_o, operand_a_o};

    function automatic alu_ctrl_t mk(input logic ill, input logic we, input logic [4:0] rd,
                                     input logic [1:0] alu, input logic cmp,
                                     input logic [1:0] sh, input logic [1:0] lg,
                                     input logic add, input logic [31:0] b,
                                     input logic [31:0] a);
        alu_ctrl_t w;
        w.illegal    = ill;
        w.rd_we      = we;
        w.rd         = rd;
        w.alu_op     = alu;
        w.compare_op = cmp;
        w.shift_op   = sh;
        w.logic_op   = lg;
        w.adder_op   = add;
        w.b          = b;
        w.a          = a;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every consume and checks hold stability.
    always @(negedge clk_i) begin
        if (rst_i) begin
            held = 1'b0;
        end else begin
            if (held && valid_o) begin
                checks++;
                if (dut_word !== held_word) begin
                    errors++;
                    $display("FAIL hold_stable: got %h expected %h", dut_word, held_word);
                end
            end
            if (valid_o && ready_i) begin
                emitted++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", dut_word);
                end else begin
                    popped = exp_q.pop_front();
                    if (dut_word !== popped) begin
                        errors++;
                        $display("FAIL output_word: got %h expected %h", dut_word, popped);
                    end
                end
            end
            held      = valid_o && !ready_i;
            held_word = dut_word;
        end
    end

    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input alu_ctrl_t e);
        bit ok;
        instruction_i = inst;
        pc_i          = pc;
        rs1_data_i    = a;
        rs2_data_i    = b;
        valid_i       = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            ok = ready_o;
            @(posedge clk_i);
            #1;
            if (ok) begin
                exp_q.push_back(e);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept expected accept for %h", inst);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk_i);
        #1;
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    alu_ctrl_t e_add, e_sra, e_lui, e_auipc, e_sltu, e_sub, e_xori, e_or, e_slli, e_slt;
    alu_ctrl_t e_ill1, e_ill2, e_ill3;
    int        emit_snap;

    initial begin
        e_add   = mk(0, 1, 5'd3, 2'b00, 0, 2'b00, 2'b00, 0, 32'd7, 32'd5);
        e_sra   = mk(0, 1, 5'd5, 2'b10, 0, 2'b10, 2'b00, 0, 32'h0000_0404, 32'h8000_0000);
        e_lui   = mk(0, 1, 5'd1, 2'b00, 0, 2'b00, 2'b00, 0, 32'h1234_5000, 32'h0);
        e_auipc = mk(0, 1, 5'd2, 2'b00, 0, 2'b00, 2'b00, 0, 32'h0000_1000, 32'h0000_0100);
        e_sltu  = mk(0, 1, 5'd4, 2'b11, 1, 2'b00, 2'b00, 0, 32'd9, 32'd3);
        e_sub   = mk(0, 1, 5'd1, 2'b00, 0, 2'b00, 2'b00, 1, 32'd3, 32'd2);
        e_xori  = mk(0, 0, 5'd0, 2'b01, 0, 2'b00, 2'b10, 0, 32'hFFFF_FFFF, 32'h0000_00AA);
        e_or    = mk(0, 1, 5'd7, 2'b01, 0, 2'b00, 2'b01, 0, 32'h0F0F_0000, 32'h0000_F0F0);
        e_slli  = mk(0, 1, 5'd6, 2'b10, 0, 2'b00, 2'b00, 0, 32'h0000_001F, 32'h0000_0001);
        e_slt   = mk(0, 1, 5'd10, 2'b11, 0, 2'b00, 2'b00, 0, 32'h0000_0001, 32'hFFFF_FFFF);
        e_ill1  = mk(1, 0, 5'd3, 2'b00, 0, 2'b00, 2'b00, 0, 32'h0, 32'h0);
        e_ill2  = mk(1, 0, 5'd0, 2'b00, 0, 2'b00, 2'b00, 0, 32'h0, 32'h0);
        e_ill3  = mk(1, 0, 5'd6, 2'b00, 0, 2'b00, 2'b00, 0, 32'h0, 32'h0);

        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        instruction_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        #12;
        chk("reset_valid_o", valid_o, 0);
        chk("reset_ready_o", ready_o, 1);
        chk("reset_operand_a", operand_a_o, 0);
        chk("reset_operand_b", operand_b_o, 0);
        chk("reset_ctrl", {illegal_o, rd_we_o, rd_o, alu_op_o}, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Back-to-back stream with the consumer always ready.
        ready_i = 1'b1;
        send(32'h0020_81B3, 32'h0, 32'd5, 32'd7, e_add);
        send(32'h4043_5293, 32'h0, 32'h8000_0000, 32'h0, e_sra);
        send(32'h1234_50B7, 32'h0, 32'hDEAD_BEEF, 32'h0, e_lui);
        send(32'h0000_1117, 32'h100, 32'hDEAD_BEEF, 32'h0, e_auipc);
        send(32'h0020_B233, 32'h0, 32'd3, 32'd9, e_sltu);
        send(32'h4031_00B3, 32'h0, 32'd2, 32'd3, e_sub);
        send(32'hFFF0_C013, 32'h0, 32'h0000_00AA, 32'h0, e_xori);
        send(32'h0094_63B3, 32'h0, 32'h0000_F0F0, 32'h0F0F_0000, e_or);
        send(32'h01F3_1313, 32'h0, 32'h0000_0001, 32'h0, e_slli);
        send(32'h00C5_A533, 32'h0, 32'hFFFF_FFFF, 32'h0000_0001, e_slt);
        send(32'h0220_81B3, 32'h0, 32'd5, 32'd7, e_ill1);
        send(32'h0000_0073, 32'h0, 32'd5, 32'd7, e_ill2);
        send(32'h4003_1313, 32'h0, 32'd5, 32'd7, e_ill3);
        valid_i = 1'b0;
        drain();

        // Backpressure: two accepted, third stalls until the skid drains.
        ready_i = 1'b0;
        send(32'h0020_81B3, 32'h0, 32'd5, 32'd7, e_add);
        send(32'h0020_B233, 32'h0, 32'd3, 32'd9, e_sltu);
        chk("ready_low_after_skid", ready_o, 0);
        instruction_i = 32'h1234_50B7;
        rs1_data_i    = 32'h0;
        valid_i       = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("ready_still_low", ready_o, 0);
        chk("held_valid", valid_o, 1);
        chk("held_operand_a", operand_a_o, 32'd5);
        ready_i = 1'b1;
        send(32'h1234_50B7, 32'h0, 32'h0, 32'h0, e_lui);
        valid_i = 1'b0;
        drain();

        // Flush with both entries held and a new input offered.
        ready_i = 1'b0;
        send(32'h0020_81B3, 32'h0, 32'd5, 32'd7, e_add);
        send(32'h4043_5293, 32'h0, 32'h8000_0000, 32'h0, e_sra);
        instruction_i = 32'h0000_1117;
        valid_i       = 1'b1;
        flush_i       = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        exp_q.delete();
        chk("flush_valid_o", valid_o, 0);
        chk("flush_ready_o", ready_o, 1);
        emit_snap = emitted;
        ready_i   = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        chk("flush_nothing_emitted", emitted, emit_snap);
        send(32'h0094_63B3, 32'h0, 32'h0000_F0F0, 32'h0F0F_0000, e_or);
        valid_i = 1'b0;
        drain();

        // Asynchronous reset in the middle of a cycle with both entries held.
        ready_i = 1'b0;
        send(32'h0020_81B3, 32'h0, 32'd5, 32'd7, e_add);
        send(32'h4043_5293, 32'h0, 32'h8000_0000, 32'h0, e_sra);
        valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        exp_q.delete();
        chk("async_rst_valid_o", valid_o, 0);
        chk("async_rst_ready_o", ready_o, 1);
        chk("async_rst_operand_a", operand_a_o, 0);
        chk("async_rst_rd", rd_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        send(32'h0000_1117, 32'h100, 32'h0, 32'h0, e_auipc);
        valid_i = 1'b0;
        drain();
        chk("emitted_total_nonzero", (emitted > 15) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
